axis_diff_sequencer: RTL and testbench

AXIS_DIFF_SEQUENCER -- requirements
Module: axis_diff_sequencer

---
 rtl/vib_seq_pkg.sv | 7 +
 rtl/axis_diff_sequencer_if.sv | 10 +
 rtl/axis_sample_fifo.sv | 39 +++
 rtl/axis_diff_sequencer.sv | 82 ++++++++
 tb/tb_axis_diff_sequencer.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/vib_seq_pkg.sv
// vib_seq_pkg: state encoding and defaults shared by the sample sequencer blocks
package vib_seq_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_RUN = 2'd2;
  localparam int FILL_COUNT_DEF = 6;
endpackage

// File: rtl/axis_diff_sequencer_if.sv
// axis_diff_sequencer_if: one AXI-Stream channel (valid/ready/data) with producer and consumer views
interface axis_diff_sequencer_if #(
  parameter int W = 16
);
  logic tvalid;
  logic tready;
  logic [W-1:0] tdata;
  modport master(output tvalid, tdata, input tready);
  modport slave(input tvalid, tdata, output tready);
endinterface

// File: rtl/axis_sample_fifo.sv
// axis_sample_fifo: synchronous FIFO with flush; a push into a full FIFO only lands if a pop frees a slot that cycle
module axis_sample_fifo #(
  parameter int W = 16,
  parameter int DEPTH = 4
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         i_flush,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_dout,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0] r_wptr, r_rptr;
  logic w_wr, w_rd;
  always_comb begin
    o_empty = r_wptr == r_rptr;
    o_full = (r_wptr ^ r_rptr) == {1'b1, {AW{1'b0}}};
    w_rd = i_pop & ~o_empty;
    w_wr = i_push & (~o_full | w_rd);
    o_dout = o_empty ? '0 : r_mem[r_rptr[AW-1:0]];
  end
  always_ff @(posedge aclk) begin
    if (!aresetn || i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      r_wptr <= r_wptr + (AW + 1)'(w_wr);
      r_rptr <= r_rptr + (AW + 1)'(w_rd);
    end
  end
  always_ff @(posedge aclk) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= i_din;
  end
endmodule

// File: rtl/axis_diff_sequencer.sv
// axis_diff_sequencer: decimates a raw sample stream into a differentiator and buffers its
// results once the differentiator pipeline has filled
module axis_diff_sequencer
  import vib_seq_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = 16,
  parameter int DECIM_WIDTH = 8,
  parameter int FILL_COUNT = FILL_COUNT_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   cfg_enable,
  input  logic [DECIM_WIDTH-1:0] cfg_decim,
  axis_diff_sequencer_if.slave   S_AXIS,
  axis_diff_sequencer_if.master  D_AXIS,
  axis_diff_sequencer_if.slave   R_AXIS,
  axis_diff_sequencer_if.master  M_AXIS,
  output logic [1:0]             status_state,
  output logic [15:0]            overflow_count
);
  localparam int FW = $clog2(FILL_COUNT + 1);
  logic [1:0] r_state, w_next;
  logic [DECIM_WIDTH-1:0] r_decim, r_cnt, w_ratio;
  logic [FW-1:0] r_fill;
  logic [AXIS_TDATA_WIDTH-1:0] r_ddata;
  logic [15:0] r_ovf;
  logic r_dvalid;
  logic w_active, w_stop, w_rechg, w_fwd, w_last_fill, w_push, w_pop, w_full, w_empty;
  assign S_AXIS.tready = 1'b1;
  assign R_AXIS.tready = 1'b1;
  assign D_AXIS.tvalid = r_dvalid;
  assign D_AXIS.tdata = r_ddata;
  assign M_AXIS.tvalid = ~w_empty;
  assign status_state = r_state;
  assign overflow_count = r_ovf;
  // Disable outranks a ratio change, which outranks the fill completing
  always_comb begin
    w_ratio = (cfg_decim == '0) ? DECIM_WIDTH'(1) : cfg_decim;
    w_active = r_state != ST_IDLE;
    w_stop = w_active & ~cfg_enable;
    w_rechg = w_active & cfg_enable & (w_ratio != r_decim);
    w_fwd = w_active & ~w_stop & ~w_rechg & S_AXIS.tvalid & (r_cnt == r_decim - DECIM_WIDTH'(1));
    w_last_fill = (r_state == ST_FILL) & R_AXIS.tvalid & (r_fill == FW'(FILL_COUNT - 1));
    w_next = !w_active ? (cfg_enable ? ST_FILL : ST_IDLE) :
             w_stop ? ST_IDLE :
             w_rechg ? ST_FILL :
             w_last_fill ? ST_RUN : r_state;
    w_push = (r_state == ST_RUN) & R_AXIS.tvalid & ~w_stop;
    w_pop = M_AXIS.tvalid & M_AXIS.tready;
  end
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state <= ST_IDLE;
      r_decim <= DECIM_WIDTH'(1);
      r_cnt <= '0;
      r_fill <= '0;
      r_dvalid <= 1'b0;
      r_ddata <= '0;
      r_ovf <= '0;
    end else begin
      r_state <= w_next;
      r_decim <= (!w_active || w_rechg) && w_next == ST_FILL ? w_ratio : r_decim;
      r_cnt <= (!w_active || w_stop || w_rechg || w_fwd) ? '0 : r_cnt + DECIM_WIDTH'(S_AXIS.tvalid);
      r_fill <= (r_state == ST_FILL && cfg_enable && !w_rechg) ? r_fill + FW'(R_AXIS.tvalid) : '0;
      r_dvalid <= w_fwd;
      r_ddata <= w_fwd ? S_AXIS.tdata : r_ddata;
      r_ovf <= (w_push && w_full && !w_pop && r_ovf != 16'hFFFF) ? r_ovf + 16'd1 : r_ovf;
    end
  end
  axis_sample_fifo #(.W(AXIS_TDATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .aclk   (aclk),
    .aresetn(aresetn),
    .i_flush(w_stop),
    .i_push (w_push),
    .i_pop  (w_pop),
    .i_din  (R_AXIS.tdata),
    .o_dout (M_AXIS.tdata),
    .o_full (w_full),
    .o_empty(w_empty)
  );
endmodule

// File: tb/tb_axis_diff_sequencer.sv
// tb_axis_diff_sequencer: directed and random stimulus against a queue-based reference model with a scoreboard monitor
module tb_axis_diff_sequencer;
  localparam int W = 16;
  localparam int FILL = 6;
  localparam int DEPTH = 4;
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic cfg_enable = 1'b0;
  logic [7:0] cfg_decim = 8'd1;
  logic [1:0] status_state;
  logic [15:0] overflow_count;
  axis_diff_sequencer_if #(.W(W)) s_if ();
  axis_diff_sequencer_if #(.W(W)) d_if ();
  axis_diff_sequencer_if #(.W(W)) r_if ();
  axis_diff_sequencer_if #(.W(W)) m_if ();
  axis_diff_sequencer dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .cfg_enable    (cfg_enable),
    .cfg_decim     (cfg_decim),
    .S_AXIS        (s_if),
    .D_AXIS        (d_if),
    .R_AXIS        (r_if),
    .M_AXIS        (m_if),
    .status_state  (status_state),
    .overflow_count(overflow_count)
  );
  always #5 aclk = ~aclk;
  int n_vec = 0;
  int n_err = 0;
  bit mon_on = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // Reference model: state, ratio, beats seen since latch, fill beats, FIFO occupancy, drops
  int m_st = 0, m_dec = 1, m_seen = 0, m_fill = 0, m_occ = 0, m_ovf = 0, m_ratio;
  bit m_pop;
  logic [W-1:0] d_q[$];
  logic [W-1:0] m_q[$];
  always @(posedge aclk) begin
    if (!aresetn) begin
      m_st = 0; m_dec = 1; m_seen = 0; m_fill = 0; m_occ = 0; m_ovf = 0;
      d_q.delete();
      m_q.delete();
    end else begin
      m_ratio = (cfg_decim == 0) ? 1 : int'(cfg_decim);
      m_pop = m_if.tready && m_occ > 0;
      if (m_st == 0) begin
        if (cfg_enable) begin
          m_st = 1; m_dec = m_ratio; m_seen = 0; m_fill = 0;
        end
      end else if (!cfg_enable) begin
        m_st = 0; m_occ = 0; m_pop = 0;
        m_q.delete();
      end else begin
        if (m_st == 2 && r_if.tvalid) begin
          if (m_occ < DEPTH || m_pop) begin
            m_q.push_back(r_if.tdata);
            m_occ++;
          end else if (m_ovf < 65535) m_ovf++;
        end
        if (m_ratio != m_dec) begin
          m_st = 1; m_dec = m_ratio; m_seen = 0; m_fill = 0;
        end else begin
          if (s_if.tvalid) begin
            m_seen++;
            if (m_seen % m_dec == 0) d_q.push_back(s_if.tdata);
          end
          if (m_st == 1 && r_if.tvalid) begin
            m_fill++;
            if (m_fill == FILL) m_st = 2;
          end
        end
      end
      if (m_pop) m_occ--;
    end
  end
  logic [W-1:0] mon_exp;
  always @(negedge aclk) begin
    if (mon_on) begin
      chk("status_state", 32'(status_state), 32'(m_st));
      chk("overflow_count", 32'(overflow_count), 32'(m_ovf));
      chk("D_tvalid", 32'(d_if.tvalid), 32'(d_q.size() != 0));
      if (d_q.size() != 0) begin
        mon_exp = d_q.pop_front();
        if (d_if.tvalid) chk("D_tdata", 32'(d_if.tdata), 32'(mon_exp));
      end
      chk("M_tvalid", 32'(m_if.tvalid), 32'(m_q.size() != 0));
      if (m_if.tvalid && m_if.tready && m_q.size() != 0) begin
        mon_exp = m_q.pop_front();
        chk("M_tdata", 32'(m_if.tdata), 32'(mon_exp));
      end
    end
  end
  task automatic cyc(input bit sv, input logic [W-1:0] sd, input bit rv, input logic [W-1:0] rd, input bit rdy);
    s_if.tvalid = sv; s_if.tdata = sd;
    r_if.tvalid = rv; r_if.tdata = rd;
    m_if.tready = rdy;
    @(posedge aclk);
    #1;
  endtask
  task automatic fill_to_run();
    for (int i = 0; i < FILL + 2; i++) cyc(0, 0, 1, W'(16'h0F00 + i), 1);
  endtask
  initial begin
    s_if.tvalid = 0; s_if.tdata = 0;
    r_if.tvalid = 0; r_if.tdata = 0;
    m_if.tready = 0; d_if.tready = 1;
    @(posedge aclk);
    #1;
    mon_on = 1;
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("reset_D_tdata", 32'(d_if.tdata), 0);
    chk("reset_M_tdata", 32'(m_if.tdata), 0);
    aresetn = 1;
    // Ramp at ratio 1: fill drops the first results, then everything flows
    cfg_enable = 1;
    cyc(0, 0, 0, 0, 1);
    for (int i = 1; i <= 20; i++) cyc(1, W'(i), 1, W'(i), 1);
    // Ratio 4 with continuous samples
    cfg_decim = 4;
    cyc(0, 0, 0, 0, 1);
    for (int i = 1; i <= 24; i++) cyc(1, W'(i), (i % 3) == 0, W'(16'h0100 + i), 1);
    // Backpressure: six results into four slots
    fill_to_run();
    for (int i = 0; i < 6; i++) cyc(0, 0, 1, W'(16'h0200 + i), 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 1);
    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, W'(16'h0300 + i), 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, W'(16'h0310 + i), 1);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 1);
    // Ratio change in RUN keeps buffered results and restarts the fill
    cfg_decim = 2;
    cyc(0, 0, 0, 0, 1);
    fill_to_run();
    cyc(0, 0, 1, 16'h0400, 0);
    cyc(0, 0, 1, 16'h0401, 0);
    cfg_decim = 3;
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) cyc(1, W'(16'h0410 + i), 1, W'(16'h0420 + i), 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, W'(16'h0430 + i), 1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1);
    // Random traffic with occasional disables, ratio changes and resets
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 39) == 0) cfg_enable = ~cfg_enable;
      if ($urandom_range(0, 29) == 0) cfg_decim = 8'($urandom_range(0, 4));
      aresetn = $urandom_range(0, 199) != 0;
      cyc($urandom_range(0, 9) < 7, W'($urandom), $urandom_range(0, 9) < 6, W'($urandom), $urandom_range(0, 1) == 1);
    end
    aresetn = 1;
    // Disable mid-RUN with traffic in flight
    cfg_enable = 1;
    cfg_decim = 1;
    cyc(0, 0, 0, 0, 1);
    fill_to_run();
    for (int i = 0; i < 3; i++) cyc(1, W'(16'h0500 + i), 1, W'(16'h0510 + i), 0);
    cfg_enable = 0;
    cyc(1, 16'h0520, 1, 16'h0521, 0);
    chk("disable_M_tvalid", 32'(m_if.tvalid), 0);
    chk("disable_state", 32'(status_state), 0);
    chk("disable_D_tvalid", 32'(d_if.tvalid), 0);
    // Reset mid-RUN with traffic in flight
    cfg_enable = 1;
    cyc(0, 0, 0, 0, 1);
    fill_to_run();
    for (int i = 0; i < 3; i++) cyc(1, W'(16'h0600 + i), 1, W'(16'h0610 + i), 0);
    aresetn = 0;
    cyc(1, 16'h0620, 1, 16'h0621, 0);
    chk("reset_run_M_tvalid", 32'(m_if.tvalid), 0);
    chk("reset_run_state", 32'(status_state), 0);
    chk("reset_run_D_tvalid", 32'(d_if.tvalid), 0);
    aresetn = 1;
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 1);
    chk("drained_M_tvalid", 32'(m_if.tvalid), 0);
    chk("final_overflow", 32'(overflow_count), 32'(m_ovf));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
